dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port 64-bit data memory between two requesters: the core load/store port and an external (loader/debug) port.
- Sits between the core datapath and the data memory.
- Sequences each access through a req/ready handshake. Stalls the core while memory is busy or granted to the external port.
- Bounds external-port starvation with a wait counter.

Parameters:
- DATA_W, 64, width of data words on all ports.
- ADDR_W, 64, width of byte addresses on all ports.
- MAX_WAIT, 4, maximum consecutive arbitration cycles the external port may lose before it is forced to win; 0 means the external port always wins.

Ports:
- clk  input  1  main clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- core_req  input  1  core access request; held high with stable fields until core_ready.
- core_wen  input  1  1 = write, 0 = read.
- core_addr  input  ADDR_W  core address.
- core_wdata  input  DATA_W  core write data.
- core_rdata  output  DATA_W  read data, valid while core_ready=1 for a read.
- core_ready  output  1  one-cycle pulse: core transaction complete.
- ext_req  input  1  external request; same holding rule as core_req.
- ext_wen  input  1  1 = write, 0 = read.
- ext_addr  input  ADDR_W  external address.
- ext_wdata  input  DATA_W  external write data.
- ext_rdata  output  DATA_W  read data, valid while ext_ack=1 for a read.
- ext_ack  output  1  one-cycle pulse: external transaction complete.
- mem_addr  output  ADDR_W  memory address.
- mem_wen  output  1  memory write enable.
- mem_ren  output  1  memory read enable.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_ren.
- stall_cnt  output  32  core stall-cycle count (see Optional Feature).

Behaviour:
- Memory contract:
  - Write commits at the clock edge where mem_wen=1.
  - Read address is sampled at the edge where mem_ren=1; mem_rdata is valid the following cycle.
  - mem_wen and mem_ren are never both 1.
- FSM states: IDLE, RD_CORE, RD_EXT.
- IDLE, winner selection:
  - ext wins if ext_req && (wait_cnt==MAX_WAIT || !core_req).
  - Otherwise core wins if core_req.
  - Otherwise no winner.
- IDLE, winner drives mem_addr/mem_wdata combinationally:
  - Write: mem_wen=1 and the winner's ready/ack pulses this same cycle (zero-wait write); stay in IDLE.
  - Read: mem_ren=1; go to RD_CORE or RD_EXT.
- RD_x state:
  - mem_ren=mem_wen=0, mem_addr=0.
  - The owner's rdata output = mem_rdata and its ready/ack=1 combinationally.
  - The rdata value is also registered and held until that requester's next read completes.
  - Unconditional return to IDLE; no new issue in this cycle. Read throughput is one per 2 cycles.
- When no access is issued, mem_* outputs are 0.
- wait_cnt, width clog2(MAX_WAIT+1):
  - Updated only on IDLE cycles.
  - Increments, saturating at MAX_WAIT, when ext_req=1 and ext loses.
  - Clears when ext wins or ext_req=0.
  - Holds in RD states.
- Simultaneous core and ext requests with wait_cnt<MAX_WAIT: core wins.
- Losing requester: keeps req asserted and receives no ready/ack.
- Handshake violations: dropping req before ready/ack is illegal. The arbiter does not abort an issued read; ready/ack still pulses.
- Reset, including mid-read:
  - State goes to IDLE and wait_cnt to 0.
  - core_rdata, ext_rdata and stall_cnt are cleared to 0.
  - All combinational outputs are 0 in the reset cycle; an in-flight read produces no ready/ack.
- Reset values: core_ready=0, ext_ack=0, core_rdata=0, ext_rdata=0, mem_addr=0, mem_wen=0, mem_ren=0, mem_wdata=0, stall_cnt=0.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - stall_cnt is a 32-bit register, reset to 0.
  - It increments each cycle with core_req=1 && core_ready=0 and wraps 0xFFFFFFFF to 0.
- Undefined: stall_cnt is tied to 0 and no counter logic is present. Port list is identical in both builds.

Test Plan:
- Core write only: core_req=1, wen=1, addr=0x10, wdata=0xA5 -> same cycle mem_wen=1, mem_addr=0x10, core_ready=1; memory word 0x10 = 0xA5.
- Core read: preload 0x18=0x1234, core read 0x18 -> cycle0 mem_ren=1; cycle1 core_ready=1, core_rdata=0x1234.
- Contention, MAX_WAIT=4: core and ext both write continuously -> core wins 4 consecutive IDLE cycles, then ext_ack on the 5th; pattern repeats and ext is never starved beyond 4 cycles.
- ext_req alone, read of preloaded 0x20=0xBEEF -> ext_ack pulses one cycle after mem_ren with ext_rdata=0xBEEF; core_ready stays 0.
- Reset mid-read: core read issued, rst=1 in the RD_CORE cycle -> no core_ready, outputs 0, wait_cnt=0; after release, a fresh core read completes normally.
- Stats (DMEM_ARB_STATS_EN): core read concurrent with ext having wait_cnt=MAX_WAIT -> stall_cnt increments exactly on cycles core_req=1 && core_ready=0 (3 after ext read plus core read). Without the macro, stall_cnt=0 throughout.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bus bundle for dmem_arbiter. It carries the core load/store
//               port, the external (loader/debug) port, the data-memory port
//               and the stall statistics output.
//               The slave modport is the arbiter's view of the bus.
//               The master modport is the view of the surrounding environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  // core load/store port
  logic              core_req;
  logic              core_wen;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_ready;
  // external port
  logic              ext_req;
  logic              ext_wen;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_ack;
  // data memory port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic              mem_ren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // statistics
  logic [31:0]       stall_cnt;

  modport slave (
    input  core_req, core_wen, core_addr, core_wdata,
    input  ext_req, ext_wen, ext_addr, ext_wdata,
    input  mem_rdata,
    output core_rdata, core_ready,
    output ext_rdata, ext_ack,
    output mem_addr, mem_wen, mem_ren, mem_wdata,
    output stall_cnt
  );

  modport master (
    output core_req, core_wen, core_addr, core_wdata,
    output ext_req, ext_wen, ext_addr, ext_wdata,
    output mem_rdata,
    input  core_rdata, core_ready,
    input  ext_rdata, ext_ack,
    input  mem_addr, mem_wen, mem_ren, mem_wdata,
    input  stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Arbitrates the single-port data memory between the core
//               load/store port and an external port.
//               Writes complete with zero wait in the issue cycle.
//               Reads take two cycles: issue, then return.
//               A wait counter bounds starvation of the external port.
//               Optional macro DMEM_ARB_STATS_EN enables the core stall-cycle
//               counter on stall_cnt. Without the macro, stall_cnt is tied to
//               zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  // MAX_WAIT = 0 still needs a one-bit counter so the compare stays legal.
  localparam int                WCNT_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCNT_W-1:0] C_WAIT_MAX = WCNT_W'(MAX_WAIT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_CORE = 2'd1;
  localparam logic [1:0] S_RD_EXT  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_ext_rdata;
  logic              w_ext_win;
  logic              w_core_win;
  logic              w_core_ready;

  // Winner selection, meaningful only in IDLE: ext wins when starved or uncontested
  assign w_ext_win  = (r_state == S_IDLE) && bus.ext_req &&
                      ((r_wait_cnt == C_WAIT_MAX) || !bus.core_req);
  assign w_core_win = (r_state == S_IDLE) && bus.core_req && !w_ext_win;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: reads go through a one-cycle return state, writes stay in IDLE
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_ext_win && !bus.ext_wen) begin
          w_state_nxt = S_RD_EXT;
        end else if (w_core_win && !bus.core_wen) begin
          w_state_nxt = S_RD_CORE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: winner drives memory in IDLE; RD states forward mem_rdata to the owner
  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_wen     = 1'b0;
    bus.mem_ren     = 1'b0;
    w_core_ready    = 1'b0;
    bus.ext_ack     = 1'b0;
    bus.core_rdata  = r_core_rdata;
    bus.ext_rdata   = r_ext_rdata;
    if (rst) begin
      bus.core_rdata = '0;
      bus.ext_rdata  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ext_win) begin
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
            bus.mem_wen   = bus.ext_wen;
            bus.mem_ren   = !bus.ext_wen;
            bus.ext_ack   = bus.ext_wen;
          end else if (w_core_win) begin
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
            bus.mem_wen   = bus.core_wen;
            bus.mem_ren   = !bus.core_wen;
            w_core_ready  = bus.core_wen;
          end
        end
        S_RD_CORE: begin
          w_core_ready   = 1'b1;
          bus.core_rdata = bus.mem_rdata;
        end
        S_RD_EXT: begin
          bus.ext_ack   = 1'b1;
          bus.ext_rdata = bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.core_ready = w_core_ready;

  // Capture returned read data so each requester sees it until its next read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_rdata <= '0;
      r_ext_rdata  <= '0;
    end else if (r_state == S_RD_CORE) begin
      r_core_rdata <= bus.mem_rdata;
    end else if (r_state == S_RD_EXT) begin
      r_ext_rdata <= bus.mem_rdata;
    end
  end

  // Starvation counter: counts IDLE-cycle losses by ext, holds during reads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (bus.ext_req && !w_ext_win) begin
        if (r_wait_cnt != C_WAIT_MAX) begin
          r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
        end
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stall_cnt;

  // Count every cycle the core is requesting without completing; wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (bus.core_req && !w_core_ready) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. It combines directed
//               scenarios with randomized traffic, and compares the DUT every
//               cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int MAXW = 4;
`ifdef DMEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(64), .ADDR_W(64)) bus ();

  dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .MAX_WAIT(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory environment: writes commit at the edge, read data appears the next cycle
  logic [63:0] mem [16];
  always @(posedge clk) begin
    if (bus.mem_wen) mem[bus.mem_addr[6:3]] <= bus.mem_wdata;
    if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr[6:3]];
  end

  // Reference model: transaction-level view of arbitration
  logic [63:0] shadow [16];
  int          m_pend  = 0;      // outstanding read: 0 none, 1 core, 2 ext
  int          m_pidx  = 0;
  int          m_wait  = 0;
  logic [63:0] m_crd   = '0;
  logic [63:0] m_erd   = '0;
  logic [31:0] m_stall = '0;

  always @(negedge clk) begin : p_model
    logic        e_cr, e_ea, e_wen, e_ren, ext_first;
    logic [63:0] e_addr, e_wd, e_crd, e_erd;
    e_cr = 0; e_ea = 0; e_wen = 0; e_ren = 0; ext_first = 0;
    e_addr = '0; e_wd = '0; e_crd = m_crd; e_erd = m_erd;
    if (rst) begin
      check("m_rst_cready", bus.core_ready, 0);
      check("m_rst_eack",   bus.ext_ack,    0);
      check("m_rst_crdata", bus.core_rdata, 0);
      check("m_rst_erdata", bus.ext_rdata,  0);
      check("m_rst_memrw",  {bus.mem_wen, bus.mem_ren}, 0);
      check("m_rst_maddr",  bus.mem_addr,   0);
      check("m_rst_mwdata", bus.mem_wdata,  0);
      check("m_rst_stall",  bus.stall_cnt,  STATS ? m_stall : 32'd0);
      m_pend = 0; m_wait = 0; m_crd = '0; m_erd = '0; m_stall = '0;
    end else begin
      if (m_pend == 1) begin
        e_cr = 1; e_crd = shadow[m_pidx];
      end else if (m_pend == 2) begin
        e_ea = 1; e_erd = shadow[m_pidx];
      end else begin
        ext_first = bus.ext_req && (m_wait >= MAXW || !bus.core_req);
        if (ext_first) begin
          e_addr = bus.ext_addr; e_wd = bus.ext_wdata;
          e_wen = bus.ext_wen; e_ren = !bus.ext_wen; e_ea = bus.ext_wen;
        end else if (bus.core_req) begin
          e_addr = bus.core_addr; e_wd = bus.core_wdata;
          e_wen = bus.core_wen; e_ren = !bus.core_wen; e_cr = bus.core_wen;
        end
      end
      check("m_core_ready", bus.core_ready, e_cr);
      check("m_ext_ack",    bus.ext_ack,    e_ea);
      check("m_core_rdata", bus.core_rdata, e_crd);
      check("m_ext_rdata",  bus.ext_rdata,  e_erd);
      check("m_mem_wen",    bus.mem_wen,    e_wen);
      check("m_mem_ren",    bus.mem_ren,    e_ren);
      check("m_mem_addr",   bus.mem_addr,   e_addr);
      check("m_mem_wdata",  bus.mem_wdata,  e_wd);
      check("m_stall_cnt",  bus.stall_cnt,  STATS ? m_stall : 32'd0);
      // advance the model across the coming clock edge
      if (bus.core_req && !e_cr) m_stall = m_stall + 32'd1;
      if (m_pend == 1) begin
        m_crd = e_crd; m_pend = 0;
      end else if (m_pend == 2) begin
        m_erd = e_erd; m_pend = 0;
      end else begin
        if (bus.ext_req && !ext_first) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
        else                            m_wait = 0;
        if (e_wen) shadow[e_addr[6:3]] = e_wd;
        if (e_ren) begin
          m_pend = ext_first ? 2 : 1;
          m_pidx = int'(e_addr[6:3]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core_drive(input logic req, input logic wen, input logic [63:0] a, input logic [63:0] d);
    bus.core_req = req; bus.core_wen = wen; bus.core_addr = a; bus.core_wdata = d;
  endtask

  task automatic ext_drive(input logic req, input logic wen, input logic [63:0] a, input logic [63:0] d);
    bus.ext_req = req; bus.ext_wen = wen; bus.ext_addr = a; bus.ext_wdata = d;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] rnd_addr(input int lo, input int hi);
    logic [63:0] a;
    a = '0;
    a[6:3] = 4'($urandom_range(hi, lo));
    return a;
  endfunction

  initial begin
    logic        cd, ed;
    logic [31:0] s0;
    logic [15:0] ack_pat;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 64'h1000 + 64'(i);
      shadow[i] = 64'h1000 + 64'(i);
    end
    bus.mem_rdata = '0;
    core_drive(0, 0, '0, '0);
    ext_drive(0, 0, '0, '0);

    // reset state
    @(negedge clk);
    check("reset_core_ready", bus.core_ready, 0);
    check("reset_mem_ren",    bus.mem_ren,    0);
    check("reset_stall",      bus.stall_cnt,  0);
    repeat (2) step();
    rst = 0;

    // core write 0x10 = 0xA5, zero-wait
    core_drive(1, 1, 64'h10, 64'hA5);
    @(negedge clk);
    check("wr_mem_wen",    bus.mem_wen,    1);
    check("wr_mem_addr",   bus.mem_addr,   64'h10);
    check("wr_mem_wdata",  bus.mem_wdata,  64'hA5);
    check("wr_core_ready", bus.core_ready, 1);
    step();
    core_drive(0, 0, '0, '0);
    check("wr_mem_word", mem[2], 64'hA5);

    // core read of preloaded 0x18
    mem[3] = 64'h1234; shadow[3] = 64'h1234;
    core_drive(1, 0, 64'h18, '0);
    @(negedge clk);
    check("rd_c0_mem_ren",    bus.mem_ren,    1);
    check("rd_c0_core_ready", bus.core_ready, 0);
    step();
    @(negedge clk);
    check("rd_c1_core_ready", bus.core_ready, 1);
    check("rd_c1_core_rdata", bus.core_rdata, 64'h1234);
    step();
    core_drive(0, 0, '0, '0);
    @(negedge clk);
    check("rd_hold_rdata", bus.core_rdata, 64'h1234);
    step();

    // contention: both write continuously, ext must win every 5th cycle
    core_drive(1, 1, rnd_addr(8, 15), rnd64());
    ext_drive(1, 1, rnd_addr(8, 15), rnd64());
    ack_pat = '0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      cd = bus.core_ready; ed = bus.ext_ack;
      ack_pat[k] = ed;
      step();
      if (cd) core_drive(1, 1, rnd_addr(8, 15), rnd64());
      if (ed) ext_drive(1, 1, rnd_addr(8, 15), rnd64());
    end
    check("contention_pattern", ack_pat[14:0], 15'b100001000010000);
    core_drive(0, 0, '0, '0);
    ext_drive(0, 0, '0, '0);
    step();

    // ext read alone of preloaded 0x20
    mem[4] = 64'hBEEF; shadow[4] = 64'hBEEF;
    ext_drive(1, 0, 64'h20, '0);
    @(negedge clk);
    check("ext_c0_mem_ren", bus.mem_ren, 1);
    check("ext_c0_ack",     bus.ext_ack, 0);
    step();
    @(negedge clk);
    check("ext_c1_ack",        bus.ext_ack,    1);
    check("ext_c1_rdata",      bus.ext_rdata,  64'hBEEF);
    check("ext_c1_core_ready", bus.core_ready, 0);
    step();
    ext_drive(0, 0, '0, '0);

    // reset in the RD_CORE cycle, then a fresh read
    core_drive(1, 0, 64'h18, '0);
    @(negedge clk);
    check("rstrd_issue", bus.mem_ren, 1);
    step();
    rst = 1;
    @(negedge clk);
    check("rstrd_no_ready", bus.core_ready, 0);
    check("rstrd_rdata0",   bus.core_rdata, 0);
    check("rstrd_ren0",     bus.mem_ren,    0);
    step();
    rst = 0;
    @(negedge clk);
    check("rstrd_reissue", bus.mem_addr, 64'h18);
    step();
    @(negedge clk);
    check("rstrd_ready", bus.core_ready, 1);
    check("rstrd_data",  bus.core_rdata, 64'h1234);
    step();
    core_drive(0, 0, '0, '0);
    step();

    // stall counting: ext starved to MAX_WAIT, then ext read vs core read
    ext_drive(1, 0, 64'h20, '0);
    core_drive(1, 1, 64'h40, rnd64());
    @(negedge clk);
    s0 = bus.stall_cnt;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("stat_core_wr", bus.core_ready, 1);
      step();
      if (k < 3) core_drive(1, 1, 64'h40, rnd64());
      else       core_drive(1, 0, 64'h18, '0);
    end
    @(negedge clk);
    check("stat_ext_wins", bus.mem_addr, 64'h20);
    step();
    @(negedge clk);
    check("stat_ext_rdata", bus.ext_rdata, 64'hBEEF);
    step();
    ext_drive(0, 0, '0, '0);
    @(negedge clk);
    check("stat_core_issue", bus.mem_addr, 64'h18);
    step();
    @(negedge clk);
    check("stat_core_rdata", bus.core_rdata, 64'h1234);
    step();
    core_drive(0, 0, '0, '0);
    @(negedge clk);
    check("stat_delta", bus.stall_cnt - s0, STATS ? 32'd3 : 32'd0);
    step();

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cd = bus.core_ready; ed = bus.ext_ack;
      step();
      rst = ($urandom_range(149, 0) == 0);
      if (!bus.core_req || cd) begin
        if ($urandom_range(3, 0) != 0) core_drive(1, 1'($urandom_range(1, 0)), rnd_addr(0, 15), rnd64());
        else                           core_drive(0, 0, '0, '0);
      end
      if (!bus.ext_req || ed) begin
        if ($urandom_range(2, 0) != 0) ext_drive(1, 1'($urandom_range(1, 0)), rnd_addr(0, 15), rnd64());
        else                           ext_drive(0, 0, '0, '0);
      end
    end
    rst = 0;
    core_drive(0, 0, '0, '0);
    ext_drive(0, 0, '0, '0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
